// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS main control FSM:
//   - state_t      : 4-bit FSM state encoding
//   - OP_*         : supported primary opcodes (instr[31:26])
//   - ALUOP_*      : aluop codes for the downstream ALU-control decoder
//   - ALUSRCB_*    : ALU B operand selects
//   - PCSRC_*      : PC source selects
// Optional feature macro: MULTICONTROL_ADDI_EN (adds the ADDIEX/ADDIWB states).
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
`ifdef MULTICONTROL_ADDI_EN
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
`endif
        ST_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicontrol_if.sv
// -----------------------------------------------------------------------------
// multicontrol_if
// Bundle between the main control FSM and the MIPS datapath.
//   master modport : the controller (drives strobes, reads opcode/mem_ready)
//   slave  modport : the datapath side (drives opcode/mem_ready, reads strobes)
// Parameter CNT_W sets the width of retire_count.
// -----------------------------------------------------------------------------
interface multicontrol_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pcwrite;
    logic             branch;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regdst;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [1:0]       aluop;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] retire_count;

    modport master (
        input  opcode, mem_ready,
        output pcwrite, branch, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc,
               aluop, instr_done, illegal_op, retire_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pcwrite, branch, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc,
               aluop, instr_done, illegal_op, retire_count
    );
endinterface

// File: rtl/multicontrol_outdec.sv
// -----------------------------------------------------------------------------
// multicontrol_outdec
// Combinational Moore output decode for the main control FSM.
// Ports:
//   i_state      current FSM state
//   i_mem_ready  memory handshake (only used in FETCH and MEMWR)
//   i_rst_n      active-low reset; forces every output to 0 while low
//   o_*          datapath strobes / selects, aluop, instr_done
// Optional feature macro: MULTICONTROL_ADDI_EN (decode of ADDIEX/ADDIWB).
// -----------------------------------------------------------------------------
module multicontrol_outdec
    import mips_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic       i_rst_n,
    output logic       o_pcwrite,
    output logic       o_branch,
    output logic       o_iord,
    output logic       o_memread,
    output logic       o_memwrite,
    output logic       o_irwrite,
    output logic       o_memtoreg,
    output logic       o_regdst,
    output logic       o_regwrite,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic [1:0] o_aluop,
    output logic       o_instr_done
);

    always_comb begin
        o_pcwrite    = 1'b0;
        o_branch     = 1'b0;
        o_iord       = 1'b0;
        o_memread    = 1'b0;
        o_memwrite   = 1'b0;
        o_irwrite    = 1'b0;
        o_memtoreg   = 1'b0;
        o_regdst     = 1'b0;
        o_regwrite   = 1'b0;
        o_alusrca    = 1'b0;
        o_alusrcb    = ALUSRCB_REG;
        o_pcsrc      = PCSRC_ALU;
        o_aluop      = ALUOP_ADD;
        o_instr_done = 1'b0;

        // Reset masks the decode so a mid-instruction abort emits no strobes.
        if (i_rst_n) begin
            case (i_state)
                ST_FETCH: begin
                    o_memread = 1'b1;
                    o_alusrcb = ALUSRCB_FOUR;
                    o_aluop   = ALUOP_ADD;
                    o_pcsrc   = PCSRC_ALU;
                    // IR and PC+4 are committed only in the cycle the read lands.
                    o_irwrite = i_mem_ready;
                    o_pcwrite = i_mem_ready;
                end
                ST_DECODE: begin
                    o_alusrcb = ALUSRCB_IMM2;
                    o_aluop   = ALUOP_ADD;
                end
                ST_MEMADR: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = ALUSRCB_IMM;
                    o_aluop   = ALUOP_ADD;
                end
                ST_MEMRD: begin
                    o_iord    = 1'b1;
                    o_memread = 1'b1;
                end
                ST_MEMWB: begin
                    o_memtoreg   = 1'b1;
                    o_regwrite   = 1'b1;
                    o_instr_done = 1'b1;
                end
                ST_MEMWR: begin
                    o_iord       = 1'b1;
                    o_memwrite   = 1'b1;
                    o_instr_done = i_mem_ready;
                end
                ST_EXECUTE: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = ALUSRCB_REG;
                    o_aluop   = ALUOP_FUNCT;
                end
                ST_ALUWB: begin
                    o_regdst     = 1'b1;
                    o_regwrite   = 1'b1;
                    o_instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    o_alusrca    = 1'b1;
                    o_aluop      = ALUOP_SUB;
                    o_pcsrc      = PCSRC_ALUOUT;
                    o_branch     = 1'b1;
                    o_instr_done = 1'b1;
                end
`ifdef MULTICONTROL_ADDI_EN
                ST_ADDIEX: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = ALUSRCB_IMM;
                    o_aluop   = ALUOP_ADD;
                end
                ST_ADDIWB: begin
                    o_regwrite   = 1'b1;
                    o_instr_done = 1'b1;
                end
`endif
                ST_JUMP: begin
                    o_pcsrc      = PCSRC_JUMP;
                    o_pcwrite    = 1'b1;
                    o_instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicontrol.sv
// -----------------------------------------------------------------------------
// multicontrol
// Multi-cycle main control FSM for the MIPS datapath. Sequences one
// instruction over 3-5 states, waits on mem_ready in memory states, and
// counts retired instructions.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   FETCH    | read instruction, PC+4 (waits on mem_ready)
//   DECODE   | register read, branch target precompute
//   MEMADR   | effective address for LW/SW
//   MEMRD    | data read (waits on mem_ready)
//   MEMWB    | load writeback, retire
//   MEMWR    | data write (waits on mem_ready), retire
//   EXECUTE  | R-type ALU op
//   ALUWB    | R-type writeback, retire
//   BRANCH   | BEQ compare and conditional PC load, retire
//   ADDIEX   | ADDI ALU op              (MULTICONTROL_ADDI_EN)
//   ADDIWB   | ADDI writeback, retire   (MULTICONTROL_ADDI_EN)
//   JUMP     | PC <= jump target, retire
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    multicontrol_if.master: opcode/mem_ready in, strobes,
//          instr_done, illegal_op, retire_count out
// Parameter CNT_W: retire counter width (wraps modulo 2^CNT_W).
// Optional feature macro: MULTICONTROL_ADDI_EN (ADDI support; otherwise
// opcode 001000 is illegal).
// -----------------------------------------------------------------------------
module multicontrol
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    multicontrol_if.master bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_illegal;
    logic             w_instr_done;
    logic [CNT_W-1:0] r_retire_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_illegal   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW,
                    OP_SW:    w_state_nxt = ST_MEMADR;
                    OP_RTYPE: w_state_nxt = ST_EXECUTE;
                    OP_BEQ:   w_state_nxt = ST_BRANCH;
`ifdef MULTICONTROL_ADDI_EN
                    OP_ADDI:  w_state_nxt = ST_ADDIEX;
`endif
                    OP_J:     w_state_nxt = ST_JUMP;
                    default: begin
                        w_state_nxt = ST_FETCH;
                        w_illegal   = 1'b1;
                    end
                endcase
            end
            // IR is stable here and DECODE already filtered to LW/SW.
            ST_MEMADR: w_state_nxt = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (bus.mem_ready) begin
                    w_state_nxt = ST_MEMWB;
                end
            end
            ST_MEMWR: begin
                if (bus.mem_ready) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXECUTE: w_state_nxt = ST_ALUWB;
`ifdef MULTICONTROL_ADDI_EN
            ST_ADDIEX:  w_state_nxt = ST_ADDIWB;
`endif
            default:    w_state_nxt = ST_FETCH;
        endcase
    end

    multicontrol_outdec u_outdec (
        .i_state      (r_state),
        .i_mem_ready  (bus.mem_ready),
        .i_rst_n      (rst_n),
        .o_pcwrite    (bus.pcwrite),
        .o_branch     (bus.branch),
        .o_iord       (bus.iord),
        .o_memread    (bus.memread),
        .o_memwrite   (bus.memwrite),
        .o_irwrite    (bus.irwrite),
        .o_memtoreg   (bus.memtoreg),
        .o_regdst     (bus.regdst),
        .o_regwrite   (bus.regwrite),
        .o_alusrca    (bus.alusrca),
        .o_alusrcb    (bus.alusrcb),
        .o_pcsrc      (bus.pcsrc),
        .o_aluop      (bus.aluop),
        .o_instr_done (w_instr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire_count <= '0;
        end else if (w_instr_done) begin
            r_retire_count <= r_retire_count + CNT_W'(1);
        end
    end

    assign bus.instr_done   = w_instr_done;
    assign bus.illegal_op   = w_illegal & rst_n;
    assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_multicontrol.sv
// -----------------------------------------------------------------------------
// tb_multicontrol
// Self-checking bench for multicontrol. Each instruction is summarised by its
// length and per-strobe activity counts; a fixed table of hand-computed
// vectors is applied first, then hand-written reset sequences, then random
// instructions checked against an arithmetic model of the instruction timing.
// Honors MULTICONTROL_ADDI_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_multicontrol;
    import mips_pkg::*;

    localparam int CNT_W = 16;
`ifdef MULTICONTROL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicontrol_if #(.CNT_W(CNT_W)) bus ();

    multicontrol #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [17:0] w_all;
    assign w_all = {bus.pcwrite, bus.branch, bus.iord, bus.memread, bus.memwrite,
                    bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
                    bus.alusrcb, bus.pcsrc, bus.aluop, bus.instr_done, bus.illegal_op};

    typedef struct {
        logic [5:0] op;
        int fw;    // mem_ready=0 cycles in FETCH
        int mw;    // mem_ready=0 cycles in MEMRD/MEMWR
        int len;   // cycles from first FETCH cycle to last cycle
        int pcw;   // cycles with pcwrite
        int irw;   // cycles with irwrite
        int mrd;   // cycles with memread
        int mwr;   // cycles with memwrite
        int rw;    // cycles with regwrite
        int m2r;   // cycles with memtoreg & regwrite
        int rdst;  // cycles with regdst & regwrite
        int funct; // cycles with aluop=10
        int sub;   // cycles with aluop=01 & pcsrc=01 & branch
        int jmp;   // cycles with pcsrc=10 & pcwrite
        int ill;   // cycles with illegal_op
        int done;  // 1 if the instruction retires
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_retire = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input int fw, input int mw, input int len,
                                input int pcw, input int irw, input int mrd, input int mwr,
                                input int rw, input int m2r, input int rdst, input int funct,
                                input int sub, input int jmp, input int ill, input int done);
        vec_t v;
        v.op = op; v.fw = fw; v.mw = mw; v.len = len; v.pcw = pcw; v.irw = irw;
        v.mrd = mrd; v.mwr = mwr; v.rw = rw; v.m2r = m2r; v.rdst = rdst;
        v.funct = funct; v.sub = sub; v.jmp = jmp; v.ill = ill; v.done = done;
        return v;
    endfunction

    // Reference model: instruction cost and strobe activity from the opcode
    // table and the wait counts, in plain arithmetic.
    function automatic vec_t model(input logic [5:0] op, input int fw, input int mw);
        vec_t v;
        v = mk(op, fw, mw, 2 + fw, 1, 1, fw + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (op == OP_LW) begin
            v.len = 5 + fw + mw; v.mrd = v.mrd + mw + 1; v.rw = 1; v.m2r = 1; v.done = 1;
        end else if (op == OP_SW) begin
            v.len = 4 + fw + mw; v.mwr = mw + 1; v.done = 1;
        end else if (op == OP_RTYPE) begin
            v.len = 4 + fw; v.rw = 1; v.rdst = 1; v.funct = 1; v.done = 1;
        end else if (op == OP_BEQ) begin
            v.len = 3 + fw; v.sub = 1; v.done = 1;
        end else if (op == OP_J) begin
            v.len = 3 + fw; v.pcw = 2; v.jmp = 1; v.done = 1;
        end else if (op == OP_ADDI && ADDI_EN) begin
            v.len = 4 + fw; v.rw = 1; v.done = 1;
        end else begin
            v.ill = 1;
        end
        return v;
    endfunction

    // Runs one instruction from FETCH, then one extra FETCH-wait cycle in
    // which the retire count and the return to FETCH are checked.
    task automatic apply(input vec_t v, input string tag);
        int c_pcw = 0, c_irw = 0, c_mrd = 0, c_mwr = 0, c_rw = 0, c_m2r = 0;
        int c_rdst = 0, c_funct = 0, c_sub = 0, c_jmp = 0, c_ill = 0, c_done = 0;
        int done_at = -1;
        bit is_mem;
        is_mem = (v.op == OP_LW) || (v.op == OP_SW);
        for (int c = 0; c < v.len; c++) begin
            @(negedge clk);
            bus.opcode = v.op;
            if (c < v.fw)                                             bus.mem_ready = 1'b0;
            else if (c == v.fw)                                       bus.mem_ready = 1'b1;
            else if (is_mem && c >= v.fw + 3 && c < v.fw + 3 + v.mw)  bus.mem_ready = 1'b0;
            else if (is_mem && c == v.fw + 3 + v.mw)                  bus.mem_ready = 1'b1;
            else                                                      bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            c_pcw   += int'(bus.pcwrite);
            c_irw   += int'(bus.irwrite);
            c_mrd   += int'(bus.memread);
            c_mwr   += int'(bus.memwrite);
            c_rw    += int'(bus.regwrite);
            c_m2r   += int'(bus.memtoreg && bus.regwrite);
            c_rdst  += int'(bus.regdst && bus.regwrite);
            c_funct += int'(bus.aluop == 2'b10);
            c_sub   += int'(bus.aluop == 2'b01 && bus.pcsrc == 2'b01 && bus.branch);
            c_jmp   += int'(bus.pcsrc == 2'b10 && bus.pcwrite);
            c_ill   += int'(bus.illegal_op);
            if (bus.instr_done) begin
                c_done++;
                done_at = c;
            end
        end
        check({tag, ".pcwrite"},  c_pcw,   v.pcw);
        check({tag, ".irwrite"},  c_irw,   v.irw);
        check({tag, ".memread"},  c_mrd,   v.mrd);
        check({tag, ".memwrite"}, c_mwr,   v.mwr);
        check({tag, ".regwrite"}, c_rw,    v.rw);
        check({tag, ".memtoreg"}, c_m2r,   v.m2r);
        check({tag, ".regdst"},   c_rdst,  v.rdst);
        check({tag, ".aluop10"},  c_funct, v.funct);
        check({tag, ".beq"},      c_sub,   v.sub);
        check({tag, ".jump"},     c_jmp,   v.jmp);
        check({tag, ".illegal"},  c_ill,   v.ill);
        check({tag, ".ndone"},    c_done,  v.done);
        check({tag, ".done_at"},  done_at, (v.done != 0) ? v.len - 1 : -1);
        exp_retire = (exp_retire + v.done) % (1 << CNT_W);

        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check({tag, ".retire_count"}, int'(bus.retire_count), exp_retire);
        check({tag, ".back_in_fetch"}, int'(bus.memread && bus.alusrcb == 2'b01 && !bus.irwrite), 1);
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op        fw mw len pcw irw mrd mwr rw m2r rdst fn sub jmp ill done
        tbl.push_back(mk(OP_LW,    0, 0, 5,  1,  1,  2,  0,  1, 1,  0,  0, 0,  0,  0,  1));
        tbl.push_back(mk(OP_LW,    2, 3, 10, 1,  1,  7,  0,  1, 1,  0,  0, 0,  0,  0,  1));
        tbl.push_back(mk(OP_SW,    0, 0, 4,  1,  1,  1,  1,  0, 0,  0,  0, 0,  0,  0,  1));
        tbl.push_back(mk(OP_SW,    1, 2, 7,  1,  1,  2,  3,  0, 0,  0,  0, 0,  0,  0,  1));
        tbl.push_back(mk(OP_RTYPE, 0, 0, 4,  1,  1,  1,  0,  1, 0,  1,  1, 0,  0,  0,  1));
        tbl.push_back(mk(OP_BEQ,   0, 0, 3,  1,  1,  1,  0,  0, 0,  0,  0, 1,  0,  0,  1));
        tbl.push_back(mk(OP_J,     0, 0, 3,  2,  1,  1,  0,  0, 0,  0,  0, 0,  1,  0,  1));
        tbl.push_back(mk(6'b111111,0, 0, 2,  1,  1,  1,  0,  0, 0,  0,  0, 0,  0,  1,  0));
        if (ADDI_EN)
            tbl.push_back(mk(OP_ADDI, 0, 0, 4, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        else
            tbl.push_back(mk(OP_ADDI, 0, 0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(OP_RTYPE, 3, 0, 7,  1,  1,  4,  0,  1, 0,  1,  1, 0,  0,  0,  1));

        // Reset: outputs forced low even with mem_ready=1 in FETCH.
        rst_n = 1'b0;
        bus.opcode = OP_LW;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_vec("reset.outputs", w_all, 18'h0);
        check("reset.retire_count", int'(bus.retire_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        check("reset.fetch_after_release", int'(bus.memread && bus.alusrcb == 2'b01), 1);

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset during MEMWR with mem_ready low: memwrite drops the same cycle.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.opcode = OP_SW;
            bus.mem_ready = (c == 0) ? 1'b1 : (c == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
        end
        check("rstwr.memwrite_before", int'(bus.memwrite), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstwr.memwrite_in_reset", int'(bus.memwrite), 0);
        check_vec("rstwr.outputs_in_reset", w_all, 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        exp_retire = 0;
        check("rstwr.retire_count", int'(bus.retire_count), 0);
        check("rstwr.in_fetch", int'(bus.memread && bus.alusrcb == 2'b01 && !bus.memwrite), 1);

        // Random instruction stream against the timing model.
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            int sel;
            sel = $urandom_range(0, 6);
            case (sel)
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_RTYPE;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                default: op = 6'($urandom);
            endcase
            apply(model(op, $urandom_range(0, 3), $urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicontrol.md
# multicontrol

Multi-cycle main control FSM for the MIPS datapath. Latches the opcode from the instruction register and sequences one instruction over 3–5 states. Each state drives the datapath strobes and the 2-bit `aluop` consumed by the ALU-control decoder directly downstream, which combines `aluop` with `funct` to form the ALU control lines. Memory states wait on a ready handshake. A retired-instruction counter is provided.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `opcode`  in  6  `instr[31:26]` from the instruction register.
- `mem_ready`  in  1  memory has completed the current read/write this cycle.
- `pcwrite`, `branch`, `iord`, `memread`, `memwrite`, `irwrite`, `memtoreg`, `regdst`, `regwrite`, `alusrca`  out  1 each  datapath strobes/selects.
- `alusrcb`  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `pcsrc`  out  2  PC select: 00 ALU result, 01 ALUOut, 10 jump target.
- `aluop`  out  2  to the ALU-control decoder: 00 add, 01 subtract, 10 use funct.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each legal instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- `retire_count`  out  CNT_W  count of `instr_done` pulses.

## Operation
- Opcodes: LW 100011, SW 101011, R-type 000000, BEQ 000100, ADDI 001000, J 000010.
- Moore FSM. Every signal not listed for a state is 0.
- FETCH:
  - Drives memread=1, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite are 1 only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE:
  - Drives alusrcb=11, aluop=00.
  - Next state: LW/SW→MEMADR, R→EXECUTE, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP.
  - Any other opcode pulses illegal_op and goes to FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW→MEMRD, SW→MEMWR.
- MEMRD: iord=1, memread=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1. Goes to FETCH.
- MEMWR:
  - Drives iord=1 and memwrite=1 (held while waiting).
  - On mem_ready: instr_done=1 and goes to FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1. Goes to FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1, instr_done=1. Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regwrite=1, instr_done=1. Goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1. Goes to FETCH.
- `opcode` is sampled only in DECODE and MEMADR. The datapath holds the IR stable from FETCH completion to the next FETCH.
- `retire_count` increments by 1 on every cycle with instr_done=1 and wraps modulo 2^CNT_W. An illegal opcode does not increment it.

## Timing
- Reset:
  - rst_n=0 at a rising edge loads state FETCH and clears retire_count to 0.
  - While rst_n=0, all outputs are forced 0 combinationally, including irwrite, pcwrite and aluop=00.
- Reset mid-instruction aborts it with no further strobes. No instr_done is issued and the counter is cleared.
- Cycle counts with mem_ready held 1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in all other states.
- Outputs are a pure decode of the state register (plus mem_ready in FETCH/MEMWR). There is no output register stage.

## Configuration
- `MULTICONTROL_ADDI_EN`:
  - Defined: ADDIEX/ADDIWB are compiled in and ADDI executes as above.
  - Undefined: those states are removed, and opcode 001000 in DECODE is treated as illegal (illegal_op pulse, return to FETCH).

## Structure
- Shared package `mips_pkg` holds:
  - the state enum (4-bit encoding);
  - opcode constants `OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_BEQ`, `OP_ADDI`, `OP_J`;
  - aluop constants `ALUOP_ADD` = 00, `ALUOP_SUB` = 01, `ALUOP_FUNCT` = 10.
- One sub-module, `multicontrol_outdec`, is combinational: state + mem_ready → all strobes. The FSM next-state logic and the counter stay in `multicontrol`.

## Test plan
- Reset, then LW with mem_ready held 1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. memtoreg=regwrite=1 in cycle 5. retire_count=1.
- LW with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMRD:
  - Instruction takes 10 cycles.
  - pcwrite and irwrite pulse exactly once.
- R-type: aluop=10 in EXECUTE only. regdst=1 in ALUWB. 4 cycles total.
- BEQ: aluop=01, pcsrc=01, branch=1 in cycle 3. Then J: pcsrc=10, pcwrite=1 in cycle 3. retire_count advances by 2.
- Opcode 111111: illegal_op pulses in DECODE, state returns to FETCH, and retire_count is unchanged. With `MULTICONTROL_ADDI_EN` undefined, 001000 behaves identically.
- rst_n=0 during MEMWR with mem_ready=0:
  - memwrite drops to 0 in the same cycle.
  - Next state is FETCH and retire_count=0.
